fetch_unit: RTL

Instruction fetch stage that consumes the `pc_src` branch decision produced by the memory stage, maintains the program counter, and fetches the next instruction over a request/acknowledge handshake to instruction memory. It holds each fetched instruction stable for the decode/execute/memory path until the control logic signals retirement, then commits the next PC. It also traps misaligned targets.

---
 rtl/fetch_unit_pkg.sv | 23 ++
 rtl/fetch_unit_if.sv | 14 +
 rtl/fetch_unit_next_pc.sv | 24 ++
 rtl/fetch_unit.sv | 115 +++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared widths, next-PC select codes and FSM encoding for the fetch stage.
package fetch_unit_pkg;

  localparam int WORD = 64;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_REG    = 2'b10;

  localparam logic [WORD-1:0] PC_STEP = WORD'(4);

  typedef enum logic [1:0] {
    FETCH_ST_FETCH = 2'd0,
    FETCH_ST_HOLD  = 2'd1,
    FETCH_ST_FAULT = 2'd2
  } fetch_state_t;

  // Instructions are 32-bit words, so every legal PC is 4-byte aligned.
  function automatic logic is_aligned(input logic [WORD-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Request/acknowledge bus between the fetch stage and instruction memory.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic            req;
  logic [WORD-1:0] addr;
  logic            ack;
  logic [31:0]     rdata;

  // The fetch stage issues requests; instruction memory answers them.
  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC selection plus the alignment check on the result.
module next_pc
  import fetch_unit_pkg::*;
(
  input  logic [WORD-1:0] pc,
  input  logic [1:0]      pc_src,
  input  logic [WORD-1:0] branch_offset,
  input  logic [WORD-1:0] reg_target,
  output logic [WORD-1:0] next_pc,
  output logic            misaligned
);

  // Select target; the reserved code 11 falls through to sequential.
  always_comb begin
    next_pc = pc + PC_STEP;
    case (pc_src)
      PC_SRC_BRANCH: next_pc = pc + {branch_offset[WORD-3:0], 2'b00};
      PC_SRC_REG:    next_pc = reg_target;
      default:       next_pc = pc + PC_STEP;
    endcase
    misaligned = !is_aligned(next_pc);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over the imem handshake,
// holds the instruction until retirement and traps misaligned targets.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [1:0]      pc_src,
  input  logic [WORD-1:0] branch_offset,
  input  logic [WORD-1:0] reg_target,
  input  logic            pc_update,
  fetch_unit_if.master    imem,
  output logic [31:0]     instr,
  output logic [WORD-1:0] instr_pc,
  output logic            instr_valid,
  output logic            fault
);

  fetch_state_t    state_reg, state_next;
  logic [WORD-1:0] pc_reg, pc_next;
  logic [31:0]     instr_reg, instr_next;
  logic [WORD-1:0] instr_pc_reg, instr_pc_next;
  logic            instr_valid_reg, instr_valid_next;
  logic            fault_reg, fault_next;
  // Low for the cycle after a reset edge so no request (and no stale ack)
  // is honoured until reset has been seen released.
  logic            req_en_reg;

  logic [WORD-1:0] target_pc;
  logic            target_misaligned;
  logic            req_active;

  // Next PC is always derived from the PC of the instruction being retired.
  next_pc u_next_pc (
    .pc            (instr_pc_reg),
    .pc_src        (pc_src),
    .branch_offset (branch_offset),
    .reg_target    (reg_target),
    .next_pc       (target_pc),
    .misaligned    (target_misaligned)
  );

  assign req_active  = (state_reg == FETCH_ST_FETCH) && req_en_reg;
  assign imem.req    = req_active;
  assign imem.addr   = pc_reg;
  assign instr       = instr_reg;
  assign instr_pc    = instr_pc_reg;
  assign instr_valid = instr_valid_reg;
  assign fault       = fault_reg;

  // Next-state logic: capture on ack in FETCH, retire in HOLD, park in FAULT.
  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    instr_next       = instr_reg;
    instr_pc_next    = instr_pc_reg;
    instr_valid_next = instr_valid_reg;
    fault_next       = fault_reg;
    case (state_reg)
      FETCH_ST_FETCH: begin
        // pc_update is ignored here, even when it coincides with the ack.
        if (req_active && imem.ack) begin
          instr_next       = imem.rdata;
          instr_pc_next    = pc_reg;
          instr_valid_next = 1'b1;
          state_next       = FETCH_ST_HOLD;
        end
      end
      FETCH_ST_HOLD: begin
        if (pc_update) begin
          instr_valid_next = 1'b0;
          pc_next          = target_pc;
          if (target_misaligned) begin
            fault_next = 1'b1;
            state_next = FETCH_ST_FAULT;
          end else begin
            state_next = FETCH_ST_FETCH;
          end
        end
      end
      FETCH_ST_FAULT: begin
        instr_valid_next = 1'b0;
        fault_next       = 1'b1;
      end
      default: begin
        state_next = FETCH_ST_FAULT;
        fault_next = 1'b1;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg       <= FETCH_ST_FETCH;
      pc_reg          <= RESET_PC;
      instr_reg       <= '0;
      instr_pc_reg    <= '0;
      instr_valid_reg <= 1'b0;
      fault_reg       <= 1'b0;
      req_en_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      instr_reg       <= instr_next;
      instr_pc_reg    <= instr_pc_next;
      instr_valid_reg <= instr_valid_next;
      fault_reg       <= fault_next;
      req_en_reg      <= 1'b1;
    end
  end

endmodule
